// File: rtl/keypad_scan_debounce.sv
// Row-scanning front end for the 4x3 matrix keypad. Each keypad row is driven
// low in turn and the active-low columns are sampled, which decodes one key per
// frame. The key is debounced over whole frames, and each physical press gives
// one key_valid pulse with its key_code.
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in_from_keypad,
    output logic [3:0] out_to_keypad,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       multi_key
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_PRESSED, ST_REL} state_t;
    typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_t;

    // Column synchronizer
    logic [2:0] col_meta, col_sync;

    // Scan and frame accumulation
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       acc_n;       // keys seen so far this frame, 2 means "more than one"
    logic [3:0]       acc_code;
    logic             frame_done;
    frame_t           frame_res;
    logic [3:0]       frame_code;

    // Current-row decode
    logic [1:0] row_lows;
    logic [1:0] row_col;
    logic [2:0] tot;
    logic [1:0] tot_sat;
    logic [3:0] merged_code;

    // Debounce FSM
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       cand, cand_n;
    logic             valid_n, held_n;
    logic [3:0]       code_n;

    // Exactly one row driven low, selected by the row index
    assign out_to_keypad = ~(4'b0001 << row_idx);

    // Two-flop synchronizer on the asynchronous column lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 3'b111;
            col_sync <= 3'b111;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values, which builds a real two-stage chain.
            col_meta <= in_from_keypad;
            col_sync <= col_meta;
        end
    end

    // Count the low columns in the current row and merge them with earlier rows of this frame
    always_comb begin
        row_lows = {1'b0, ~col_sync[0]} + {1'b0, ~col_sync[1]} + {1'b0, ~col_sync[2]};
        if (!col_sync[0])      row_col = 2'd0;
        else if (!col_sync[1]) row_col = 2'd1;
        else                   row_col = 2'd2;
        tot         = {1'b0, acc_n} + {1'b0, row_lows};
        tot_sat     = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        merged_code = (acc_n == 2'd0) ? ({2'b00, row_idx} * 4'd3 + {2'b00, row_col}) : acc_code;
    end

    // Row dwell timer, per-row sampling and frame result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            row_idx    <= 2'd0;
            acc_n      <= 2'd0;
            acc_code   <= 4'd0;
            frame_done <= 1'b0;
            frame_res  <= FR_NONE;
            frame_code <= 4'd0;
            multi_key  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                if (row_idx == 2'd3) begin
                    frame_done <= 1'b1;
                    frame_code <= merged_code;
                    multi_key  <= (tot > 3'd1);
                    if (tot == 3'd0)      frame_res <= FR_NONE;
                    else if (tot == 3'd1) frame_res <= FR_SINGLE;
                    else                  frame_res <= FR_MULTI;
                    acc_n    <= 2'd0;
                    acc_code <= 4'd0;
                end else begin
                    acc_n    <= tot_sat;
                    acc_code <= merged_code;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Debounce state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cand      <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_valid <= valid_n;
            key_code  <= code_n;
            key_held  <= held_n;
        end
    end

    // Debounce next-state: advances once per completed frame
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value unassigned and no latch is inferred.
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        valid_n = 1'b0;
        code_n  = key_code;
        held_n  = key_held;
        if (frame_done) begin
            unique case (state)
                ST_IDLE, ST_CAND: begin
                    if (frame_res == FR_SINGLE) begin
                        state_n = ST_CAND;
                        if (state == ST_CAND && frame_code == cand) begin
                            cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                        end else begin
                            cand_n = frame_code;
                            cnt_n  = CNT_ONE;
                        end
                        if (cnt_n >= CNT_MAX) begin
                            valid_n = 1'b1;
                            code_n  = cand_n;
                            held_n  = 1'b1;
                            state_n = ST_PRESSED;
                            cnt_n   = '0;
                        end
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end
                ST_PRESSED, ST_REL: begin
                    if (frame_res == FR_NONE) begin
                        state_n = ST_REL;
                        if (state == ST_REL) cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                        else                 cnt_n = CNT_ONE;
                        if (cnt_n >= CNT_MAX) begin
                            held_n  = 1'b0;
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end
                    end else begin
                        state_n = ST_PRESSED;
                        cnt_n   = '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Testbench for keypad_scan_debounce. A keypad model pulls columns low for the
// pressed keys on the driven row. A frame-level reference model computes the
// expected press events, and a monitor compares them to each key_valid pulse.
module tb_keypad_scan_debounce;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] in_from_keypad;
    logic [3:0] out_to_keypad;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       multi_key;

    logic [11:0] pressed = 12'd0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;
    int fidx;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state: run lengths of identical frames
    bit m_held;
    int m_code;
    int m_run_code;
    int m_run_len;
    int m_rel_len;

    keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_from_keypad(in_from_keypad),
        .out_to_keypad (out_to_keypad),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_held      (key_held),
        .multi_key     (multi_key)
    );

    always #5 clk = ~clk;

    // Cycles since reset release, for pulse timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Keypad matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        in_from_keypad = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!out_to_keypad[r] && pressed[3*r+c]) in_from_keypad[c] = 1'b0;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Monitor: every key_valid pulse must match the next expected event
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            check("pulse_expected", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_code", int'(key_code), int'(e.code));
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic model_reset();
        m_held     = 1'b0;
        m_code     = 0;
        m_run_code = -1;
        m_run_len  = 0;
        m_rel_len  = 0;
        fidx       = 0;
    endtask

    // One frame of the reference model, driven only by the set of pressed keys
    task automatic model_frame(input logic [11:0] keys);
        int n;
        int code;
        exp_t e;
        n    = $countones(keys);
        code = 0;
        for (int k = 0; k < 12; k++) if (keys[k]) code = k;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run_len > 0 && code == m_run_code) m_run_len++;
                else begin
                    m_run_code = code;
                    m_run_len  = 1;
                end
                if (m_run_len >= DB) begin
                    e.code = 4'(code);
                    e.cyc  = FRAME * (fidx + 1) + 1;
                    sb_q.push_back(e);
                    m_held    = 1'b1;
                    m_code    = code;
                    m_run_len = 0;
                    m_rel_len = 0;
                end
            end else begin
                m_run_len = 0;
            end
        end else begin
            if (n == 0) begin
                m_rel_len++;
                if (m_rel_len >= DB) begin
                    m_held    = 1'b0;
                    m_rel_len = 0;
                    m_run_len = 0;
                end
            end else begin
                m_rel_len = 0;
            end
        end
        fidx++;
    endtask

    // Hold a key set for one full frame, then check the frame-level outputs
    task automatic run_frame(input logic [11:0] keys, input bit chk_rows);
        logic [3:0] er;
        pressed = keys;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk);
            #1;
            if (chk_rows && (i % SCAN_DIV) == 0) begin
                er = 4'b1111;
                er[(i / SCAN_DIV) % 4] = 1'b0;
                check("row_drive", int'(out_to_keypad), int'(er));
                check("no_pulse_idle", int'(key_valid), 0);
            end
        end
        check("multi_key", int'(multi_key), int'($countones(keys) > 1));
        check("key_held", int'(key_held), int'(m_held));
        check("key_code", int'(key_code), m_code);
        model_frame(keys);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_rows", int'(out_to_keypad), 14);
        check("rst_valid", int'(key_valid), 0);
        check("rst_code", int'(key_code), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_multi", int'(multi_key), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [11:0] key(input int k);
        logic [11:0] m;
        m = 12'd0;
        m[k] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [11:0] mask;
        int r;
        #2;
        do_reset();

        // Row sequence out of reset, no key
        run_frame(12'd0, 1'b1);

        // Steady hold of key 7 (row 2, col 1)
        repeat (25) run_frame(key(7), 1'b0);
        repeat (DB) run_frame(12'd0, 1'b0);

        // Bounce on key 4, then stable
        run_frame(key(4), 1'b0);
        run_frame(12'd0, 1'b0);
        run_frame(key(4), 1'b0);
        run_frame(12'd0, 1'b0);
        repeat (4) run_frame(key(4), 1'b0);
        repeat (DB) run_frame(12'd0, 1'b0);

        // Two keys together, then one released
        repeat (3) run_frame(key(0) | key(5), 1'b0);
        repeat (4) run_frame(key(5), 1'b0);
        repeat (DB) run_frame(12'd0, 1'b0);

        // Short release does not re-trigger, full release does
        repeat (DB) run_frame(key(11), 1'b0);
        run_frame(12'd0, 1'b0);
        repeat (2) run_frame(key(11), 1'b0);
        repeat (DB) run_frame(12'd0, 1'b0);
        repeat (DB) run_frame(key(11), 1'b0);
        repeat (DB) run_frame(12'd0, 1'b0);

        // Reset while a candidate is two frames in, key kept down throughout
        do_reset();
        repeat (2) run_frame(key(2), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        repeat (4) run_frame(key(2), 1'b0);
        repeat (DB) run_frame(12'd0, 1'b0);

        // Randomized key activity with a bias toward persistence
        mask = 12'd0;
        for (int f = 0; f < 80; f++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)      mask = mask;
            else if (r < 7) mask = 12'd0;
            else if (r < 9) mask = key(int'($urandom_range(0, 11)));
            else            mask = key(int'($urandom_range(0, 11))) | key(int'($urandom_range(0, 11)));
            run_frame(mask, 1'b0);
        end
        repeat (DB) run_frame(12'd0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
